regfile_mp: RTL and testbench

- Parametrised multi-read-port register file; next generation of the team's 2-read/1-write async-read RAM.
- Adds a configurable read-port count, an optional hardwired-zero entry, a post-reset hardware clear sweep with a ready flag, and a write-error flag.
- Sits in the datapath as the architectural register file; the decode stage reads it and the writeback stage writes it.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_rdport.sv | 57 +++++
 rtl/regfile_mp.sv | 105 ++++++++++
 tb/tb_regfile_mp.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the architectural register file.
//   rf_state_e    : clear-sweep FSM state (RF_INIT, RF_READY)
//   rf_depth()    : entry count for a given address width
//   RF_*          : default widths shared with the decode and writeback stages
package regfile_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_NUM_RD     = 2;

    typedef enum logic {
        RF_INIT,
        RF_READY
    } rf_state_e;

    function automatic int unsigned rf_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one asynchronous read port of regfile_mp.
// Optional feature macro: REGFILE_BYPASS_EN (write-first forwarding of i_wdata).
// Ports:
//   i_rd_en   : array is valid (clear sweep finished); otherwise reads return 0
//   i_raddr   : read address for this port
//   i_mem     : storage array contents
//   i_wr_en   : a write that will actually be committed this cycle
//   i_waddr   : write address
//   i_wdata   : write data
//   o_rdata   : read data
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = rf_depth(ADDR_WIDTH),
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic [DATA_WIDTH-1:0] i_mem [DEPTH],
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic w_zero_hit;

    assign w_zero_hit = (ZERO_REG != 0) && (i_raddr == '0);

`ifdef REGFILE_BYPASS_EN
    // i_wr_en already excludes dropped writes, so zero-entry priority holds here too.
    logic w_fwd;

    assign w_fwd = i_wr_en && (i_waddr == i_raddr);

    always_comb begin
        o_rdata = '0;
        if (i_rd_en && !w_zero_hit) begin
            o_rdata = w_fwd ? i_wdata : i_mem[i_raddr];
        end
    end
`else
    logic w_unused_bypass;

    assign w_unused_bypass = ^{i_wr_en, i_waddr, i_wdata};

    always_comb begin
        o_rdata = '0;
        if (i_rd_en && !w_zero_hit) begin
            o_rdata = i_mem[i_raddr];
        end
    end
`endif

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port architectural register file with post-reset clear sweep.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
// Ports:
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_we      : write enable
//   i_waddr   : write address
//   i_wdata   : write data
//   i_raddr   : packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   o_rdata   : packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_ready   : high once every entry has been cleared
//   o_wr_err  : one-cycle pulse after a rejected write (during sweep or to entry 0)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned NUM_RD     = RF_NUM_RD,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_we,
    input  logic [ADDR_WIDTH-1:0]        i_waddr,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rdata,
    output logic                         o_ready,
    output logic                         o_wr_err
);

    localparam int unsigned DEPTH = rf_depth(ADDR_WIDTH);
    // One extra bit so the terminal compare never wraps.
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

    rf_state_e             r_state;
    logic [ADDR_WIDTH:0]   r_clr_cnt;
    logic                  r_ready;
    logic                  r_wr_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_zero_waddr;
    logic w_wr_ok;
    logic w_rd_en;

    assign w_zero_waddr = (ZERO_REG != 0) && (i_waddr == '0);
    assign w_rd_en      = (r_state == RF_READY);
    assign w_wr_ok      = w_rd_en && i_we && !w_zero_waddr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= RF_INIT;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            r_wr_err <= i_we && ((r_state == RF_INIT) || w_zero_waddr);
            case (r_state)
                RF_INIT: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state <= RF_READY;
                        r_ready <= 1'b1;
                    end
                end
                RF_READY: begin
                    r_state <= RF_READY;
                end
                default: begin
                    r_state <= RF_INIT;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep owns the write port until it completes.
    always_ff @(posedge i_clk) begin
        if (r_state == RF_INIT) begin
            r_mem[r_clr_cnt[ADDR_WIDTH-1:0]] <= '0;
        end else if (w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rdport
        regfile_rdport #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH),
            .ZERO_REG   (ZERO_REG)
        ) u_rdport (
            .i_rd_en (w_rd_en),
            .i_raddr (i_raddr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_mem   (r_mem),
            .i_wr_en (w_wr_ok),
            .i_waddr (i_waddr),
            .i_wdata (i_wdata),
            .o_rdata (o_rdata[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign o_ready  = r_ready;
    assign o_wr_err = r_wr_err;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter DUT
    logic              rst_n;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic              ready;
    logic              wr_err;

    // NUM_RD=4, ADDR_WIDTH=3 variant
    logic          v_rst_n;
    logic          v_we;
    logic [2:0]    v_waddr;
    logic [31:0]   v_wdata;
    logic [11:0]   v_raddr;
    logic [127:0]  v_rdata;
    logic          v_ready;
    logic          v_wr_err;

    regfile_mp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RD     (NRD),
        .ZERO_REG   (1)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_we     (we),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_raddr  (raddr),
        .o_rdata  (rdata),
        .o_ready  (ready),
        .o_wr_err (wr_err)
    );

    regfile_mp #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (3),
        .NUM_RD     (4),
        .ZERO_REG   (1)
    ) dut_v (
        .i_clk    (clk),
        .i_rst_n  (v_rst_n),
        .i_we     (v_we),
        .i_waddr  (v_waddr),
        .i_wdata  (v_wdata),
        .i_raddr  (v_raddr),
        .o_rdata  (v_rdata),
        .o_ready  (v_ready),
        .o_wr_err (v_wr_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: array contents, edges since reset release, last error flag.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt;
    logic          m_err;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        eerr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
        if (!rst_n || m_cnt < DEPTH) return '0;
        if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == a) return wdata;
`endif
        return m_mem[a];
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            m_err = we && (m_cnt < DEPTH || waddr == '0);
            if (m_cnt >= DEPTH && we && waddr != '0) m_mem[waddr] = wdata;
            if (m_cnt < DEPTH) m_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic check_rd(input string name);
        check({name, ".rd0"}, rdata[0 +: DW], exp_rd(raddr[0 +: AW]));
        check({name, ".rd1"}, rdata[DW +: DW], exp_rd(raddr[AW +: AW]));
    endtask

    task automatic check_all(input string name);
        check({name, ".ready"}, {31'd0, ready}, {31'd0, (m_cnt >= DEPTH)});
        check({name, ".wr_err"}, {31'd0, wr_err}, {31'd0, m_err});
        check_rd(name);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        foreach (m_mem[i]) m_mem[i] = '0;
        #1;
        check("async_rst.ready", {31'd0, ready}, 32'd0);
        check("async_rst.wr_err", {31'd0, wr_err}, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr   = '0;
        v_rst_n = 1'b0;
        v_we    = 1'b0;
        v_waddr = '0;
        v_wdata = '0;
        v_raddr = '0;
        m_cnt   = 0;
        m_err   = 1'b0;
        foreach (m_mem[i]) m_mem[i] = '0;

        //            we   waddr  wdata          r0  r1  e0             e1             err
        vecs[0] = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd0,  32'h0,        32'h0,        1'b0};
        vecs[1] = '{1'b1, 5'd7,  32'h12345678, 5'd3, 5'd4,  32'h0,        32'h0,        1'b0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd7,  32'h12345678, 32'h12345678, 1'b0};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd7,  32'h0,        32'h12345678, 1'b1};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd31, 32'h0,        32'h0,        1'b0};
        vecs[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd7, 5'd0,  32'h12345678, 32'h0,        1'b0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};

        // Held in reset
        repeat (3) tick();
        set_rd(5'($urandom), 5'($urandom));
        #1;
        check_all("reset");

        // Sweep; a write attempt at edge 3 must be rejected
        rst_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            we    = (k == 3);
            waddr = 5'd5;
            wdata = 32'hDEADBEEF;
            set_rd(5'($urandom), 5'($urandom));
            tick();
            check_all($sformatf("sweep%0d", k));
        end
        we = 1'b0;

        // Every entry cleared
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(5'(a), 5'(a));
            #1;
            check($sformatf("clear%0d.rd0", a), rdata[0 +: DW], 32'h0);
            check($sformatf("clear%0d.rd1", a), rdata[DW +: DW], 32'h0);
        end

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            we    = vecs[i].we;
            waddr = vecs[i].waddr;
            wdata = vecs[i].wdata;
            set_rd(vecs[i].r0, vecs[i].r1);
            tick();
            check($sformatf("vec%0d.rd0", i), rdata[0 +: DW], vecs[i].e0);
            check($sformatf("vec%0d.rd1", i), rdata[DW +: DW], vecs[i].e1);
            check($sformatf("vec%0d.wr_err", i), {31'd0, wr_err}, {31'd0, vecs[i].eerr});
        end
        we = 1'b0;

        // Read during write of entry 9
        we    = 1'b1;
        waddr = 5'd9;
        wdata = 32'hA5A5A5A5;
        set_rd(5'd3, 5'd9);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw.same", rdata[DW +: DW], 32'hA5A5A5A5);
`else
        check("rdw.same", rdata[DW +: DW], 32'h0);
`endif
        check("rdw.other", rdata[0 +: DW], 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("rdw.next", rdata[DW +: DW], 32'hA5A5A5A5);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            we    = 1'($urandom_range(0, 1));
            waddr = 5'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 3) == 0) set_rd(waddr, 5'($urandom));
            else if ($urandom_range(0, 3) == 0) set_rd(5'($urandom), waddr);
            else set_rd(5'($urandom), 5'($urandom));
            #1;
            check_rd($sformatf("rnd%0d.pre", n));
            tick();
            check_all($sformatf("rnd%0d.post", n));
        end

        // Mid-sweep reset
        we    = 1'b1;
        waddr = 5'd12;
        wdata = 32'h600DF00D;
        tick();
        we = 1'b0;
        set_rd(5'd12, 5'd12);
        #1;
        check("pre_rst.rd0", rdata[0 +: DW], 32'h600DF00D);
        do_reset();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            check_all($sformatf("sweep2_%0d", k));
        end
        do_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            set_rd(5'($urandom), 5'($urandom));
            tick();
            check_all($sformatf("sweep3_%0d", k));
        end
        set_rd(5'd12, 5'd9);
        #1;
        check("post_rst.rd0", rdata[0 +: DW], 32'h0);
        check("post_rst.rd1", rdata[DW +: DW], 32'h0);

        // NUM_RD=4, ADDR_WIDTH=3 variant
        v_rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("v_sweep%0d.ready", k), {31'd0, v_ready}, {31'd0, (k == 8)});
        end
        for (int k = 1; k <= 7; k++) begin
            v_we    = 1'b1;
            v_waddr = 3'(k);
            v_wdata = 32'h11 * k;
            tick();
            check($sformatf("v_wr%0d.wr_err", k), {31'd0, v_wr_err}, 32'd0);
        end
        v_we    = 1'b0;
        v_raddr = {3'd7, 3'd5, 3'd3, 3'd1};
        #1;
        check("v_rd.p0", v_rdata[0 +: 32], 32'h11);
        check("v_rd.p1", v_rdata[32 +: 32], 32'h33);
        check("v_rd.p2", v_rdata[64 +: 32], 32'h55);
        check("v_rd.p3", v_rdata[96 +: 32], 32'h77);
        v_raddr = {3'd0, 3'd6, 3'd4, 3'd2};
        #1;
        check("v_rd2.p0", v_rdata[0 +: 32], 32'h22);
        check("v_rd2.p1", v_rdata[32 +: 32], 32'h44);
        check("v_rd2.p2", v_rdata[64 +: 32], 32'h66);
        check("v_rd2.p3", v_rdata[96 +: 32], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
